sync_blank_gen: RTL
===================

SYNC_BLANK_GEN -- requirements
Module: sync_blank_gen

Interface
REQ-001 Parameter CNT_W, default 11: width of pixel and line counters.
REQ-002 Parameter CE_DIV, default 2: clocks per pixel; power of two, 1..16.
REQ-003 Parameter HB_START, default 336: pixel index at which HBlank asserts.
REQ-004 Parameter HB_END, default 40: pixel index at which HBlank deasserts.
REQ-005 Parameter VB_START, default 246: line index at which VBlank asserts.
REQ-006 Parameter VB_END, default 6: line index at which VBlank deasserts.
REQ-007 Parameter LOCK_FRAMES, default 2: consecutive identical frame lengths required for lock; range 1..15.
REQ-008 clk_sys  input  1  system clock; all logic on rising edge.
REQ-009 reset_n  input  1  asynchronous active-low reset.
REQ-010 hs  input  1  horizontal sync from core, active high, synchronous to clk_sys.
REQ-011 vs  input  1  vertical sync from core, active high, synchronous to clk_sys.
REQ-012 ce_pix  output  1  pixel clock enable.
REQ-013 hblank  output  1  registered horizontal blank.
REQ-014 vblank  output  1  registered vertical blank.
REQ-015 line_len  output  CNT_W  clocks in last complete line.
REQ-016 frame_lines  output  CNT_W  lines in last complete frame.
REQ-017 locked  output  1  frame geometry stable.

Function
REQ-018 hs_d/vs_d shall be one-cycle registered copies of hs/vs; hs rise = hs & ~hs_d.
REQ-019 pcnt shall increment by 1 each clock, saturating at all-ones.
REQ-020 On hs rise, pcnt shall load 0 (overrides increment) and line_len shall load the pre-clear pcnt value plus 1, saturating at all-ones.
REQ-021 ce_pix shall be 1 exactly when pcnt mod CE_DIV equals CE_DIV-1 (CE_DIV=1: ce_pix constantly 1 outside reset).
REQ-022 Pixel index pix = pcnt / CE_DIV (right shift by log2(CE_DIV)).
REQ-023 hblank shall set on the clock after pix==HB_START and clear on the clock after pix==HB_END; otherwise hold.
REQ-024 vs edge shall be evaluated only on hs-rise cycles; vs_d updates only on those cycles.
REQ-025 On hs rise, lcnt shall increment saturating at all-ones; if vs rise is detected on the same cycle, lcnt shall load 0 instead.
REQ-026 On vs-rise cycle, frame_lines shall load pre-clear lcnt plus 1, saturating.
REQ-027 vblank shall set on the clock after lcnt==VB_START and clear on the clock after lcnt==VB_END; otherwise hold.
REQ-028 Lock FSM states UNLOCKED, TRACKING, LOCKED; match counter mcnt, 4 bits.
REQ-029 UNLOCKED: on vs-rise capture, store it as reference length, mcnt=0, go TRACKING.
REQ-030 TRACKING: capture equal to reference -> mcnt+1; at mcnt+1==LOCK_FRAMES go LOCKED; unequal -> new reference, mcnt=0, remain TRACKING.
REQ-031 LOCKED: capture unequal -> UNLOCKED same clock; locked=1 only in LOCKED.
REQ-032 lcnt reaching saturation in any state shall force UNLOCKED.
REQ-033 The first vs rise after reset shall be treated as a partial frame: frame_lines captured but ignored by the FSM.

Reset
REQ-034 While reset_n=0: pcnt, lcnt, line_len, frame_lines, mcnt = 0; hs_d, vs_d = 0; hblank = vblank = 1; ce_pix = 0; locked = 0; FSM UNLOCKED.
REQ-035 Reset assertion mid-line or mid-frame shall take effect immediately; first partial frame after deassertion follows REQ-033.

Verification
REQ-036 Defaults, hs period 768 clocks, 262 lines/frame -> line_len=768; hblank high from clock after pcnt=672 until clock after pcnt=80; ce_pix every 2nd clock.
REQ-037 Same stimulus -> frame_lines=262 after second vs; locked=1 after third vs rise (two matching captures), vblank lines 246..5 inclusive.
REQ-038 Locked, then one frame of 263 lines -> locked=0 on that capture cycle; relocks after two further 263-line frames.
REQ-039 hs held low for 4096 clocks -> pcnt saturates at 2047, no wrap; next hs rise gives line_len=2047.
REQ-040 hs rise and vs rise same cycle -> lcnt=0, frame_lines captured, no extra increment.
REQ-041 reset_n pulsed low mid-frame with locked=1 -> all outputs per REQ-034 asynchronously; locked stays 0 until LOCK_FRAMES full frames follow the first partial one.

Source files
------------

// File: rtl/sync_blank_gen.sv
// Sync-driven blanking generator.
// Measures line length from hs and frame height from vs, derives the pixel
// clock enable and registered hblank/vblank, and reports when the frame
// geometry has repeated often enough to be trusted.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_UNLOCKED  | no reference frame length; next capture becomes reference
// ST_TRACKING  | reference held; counting captures that repeat it
// ST_LOCKED    | geometry stable; locked asserted
module sync_blank_gen #(
  parameter int CNT_W       = 11,
  parameter int CE_DIV      = 2,
  parameter int HB_START    = 336,
  parameter int HB_END      = 40,
  parameter int VB_START    = 246,
  parameter int VB_END      = 6,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             hs,
  input  logic             vs,
  output logic             ce_pix,
  output logic             hblank,
  output logic             vblank,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] frame_lines,
  output logic             locked
);

  localparam int               CE_SH      = $clog2(CE_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CE_MASK    = CNT_W'(CE_DIV - 1);
  localparam logic [CNT_W-1:0] HB_START_C = CNT_W'(HB_START);
  localparam logic [CNT_W-1:0] HB_END_C   = CNT_W'(HB_END);
  localparam logic [CNT_W-1:0] VB_START_C = CNT_W'(VB_START);
  localparam logic [CNT_W-1:0] VB_END_C   = CNT_W'(VB_END);
  localparam logic [4:0]       LF_C       = 5'(LOCK_FRAMES);

  typedef enum logic [1:0] {ST_UNLOCKED, ST_TRACKING, ST_LOCKED} lock_st_e;

  logic             hs_d_q, vs_d_q, vs_d_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, lcnt_q, lcnt_d;
  logic [CNT_W-1:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic             hblank_q, hblank_d, vblank_q, vblank_d;
  logic [CNT_W-1:0] pcnt_inc, lcnt_inc, pix;
  logic             hs_rise, vs_rise;

  lock_st_e         state_q;
  logic [3:0]       mcnt_q;
  logic [CNT_W-1:0] ref_len_q;
  logic             first_q, locked_q;
  logic [4:0]       mcnt_p2;

  assign hs_rise  = hs & ~hs_d_q;
  // vs is only meaningful at line starts, so its edge is qualified by hs rise.
  assign vs_rise  = hs_rise & vs & ~vs_d_q;
  assign pcnt_inc = (pcnt_q == CNT_MAX) ? CNT_MAX : pcnt_q + 1'b1;
  assign lcnt_inc = (lcnt_q == CNT_MAX) ? CNT_MAX : lcnt_q + 1'b1;
  assign pix      = pcnt_q >> CE_SH;
  // With CE_DIV=1 the mask is zero, leaving ce_pix high whenever out of reset.
  assign ce_pix   = reset_n & ((pcnt_q & CE_MASK) == CE_MASK);
  assign mcnt_p2  = {1'b0, mcnt_q} + 5'd2;

  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign locked      = locked_q;

  // Next-state for the line/frame counters and blanking flags.
  always_comb begin
    pcnt_d        = hs_rise ? '0 : pcnt_inc;
    line_len_d    = hs_rise ? pcnt_inc : line_len_q;
    vs_d_d        = hs_rise ? vs : vs_d_q;
    lcnt_d        = lcnt_q;
    if (vs_rise)      lcnt_d = '0;
    else if (hs_rise) lcnt_d = lcnt_inc;
    frame_lines_d = vs_rise ? lcnt_inc : frame_lines_q;
    hblank_d      = hblank_q;
    if (pix == HB_START_C)    hblank_d = 1'b1;
    else if (pix == HB_END_C) hblank_d = 1'b0;
    vblank_d      = vblank_q;
    if (lcnt_q == VB_START_C)    vblank_d = 1'b1;
    else if (lcnt_q == VB_END_C) vblank_d = 1'b0;
  end

  // Counter, measurement and blanking registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_d_q        <= 1'b0;
      vs_d_q        <= 1'b0;
      pcnt_q        <= '0;
      lcnt_q        <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
    end else begin
      hs_d_q        <= hs;
      vs_d_q        <= vs_d_d;
      pcnt_q        <= pcnt_d;
      lcnt_q        <= lcnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
    end
  end

  // Lock tracker; the reference capture counts as the first of the
  // LOCK_FRAMES identical lengths, so each match adds one more.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_UNLOCKED;
      mcnt_q    <= '0;
      ref_len_q <= '0;
      first_q   <= 1'b1;
      locked_q  <= 1'b0;
    end else begin
      if (vs_rise) first_q <= 1'b0;
      if (lcnt_q == CNT_MAX) begin
        state_q  <= ST_UNLOCKED;
        mcnt_q   <= '0;
        locked_q <= 1'b0;
      end else if (vs_rise && !first_q) begin
        case (state_q)
          ST_UNLOCKED: begin
            ref_len_q <= lcnt_inc;
            mcnt_q    <= '0;
            state_q   <= ST_TRACKING;
            locked_q  <= 1'b0;
          end
          ST_TRACKING: begin
            if (lcnt_inc == ref_len_q) begin
              mcnt_q <= mcnt_q + 4'd1;
              if (mcnt_p2 >= LF_C) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              ref_len_q <= lcnt_inc;
              mcnt_q    <= '0;
            end
          end
          ST_LOCKED: begin
            if (lcnt_inc != ref_len_q) begin
              state_q  <= ST_UNLOCKED;
              mcnt_q   <= '0;
              locked_q <= 1'b0;
            end
          end
          default: begin
            state_q  <= ST_UNLOCKED;
            mcnt_q   <= '0;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
